// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer and one-hot grant.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic last;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = (last == ID_M1) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

    // Pointer starts at m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= ID_M1;
        end else if (update && (grant != 2'b00)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port RAM, one access per 3 cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting; grants and latches one request when any is valid
// ST_ACCESS | drives the latched access to the RAM, captures read data
// ST_RESP   | pulses rsp_valid to the granted requester
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        grant;
    logic              accept;
    logic              lat_we;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;

    // Outputs are forced low while rst is high so an aborted access cannot write or respond.
    assign accept = (state == ST_IDLE) && !rst && (m0_req_valid || m1_req_valid);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({m1_req_valid, m0_req_valid}),
        .update (accept),
        .grant  (grant)
    );

    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt    = state;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        m0_rsp_rdata = '0;
        m1_rsp_rdata = '0;
        ram_rw       = 1'b0;
        case (state)
            ST_IDLE: begin
                m0_req_ready = accept && grant[0];
                m1_req_ready = accept && grant[1];
                if (accept) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_rw    = lat_we && !rst;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!rst) begin
                    if (lat_id == ID_M0) begin
                        m0_rsp_valid = 1'b1;
                        m0_rsp_rdata = lat_we ? '0 : rdata_q;
                    end else begin
                        m1_rsp_valid = 1'b1;
                        m1_rsp_rdata = lat_we ? '0 : rdata_q;
                    end
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch on accept and read-data capture during a read access.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_id    <= ID_M0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_id    <= grant[1];
                lat_we    <= grant[1] ? m1_req_we    : m0_req_we;
                lat_addr  <= grant[1] ? m1_req_addr  : m0_req_addr;
                lat_wdata <= grant[1] ? m1_req_wdata : m0_req_wdata;
            end
            if ((state == ST_ACCESS) && !lat_we) begin
                rdata_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
    logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_rw       (ram_rw),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    // Environment RAM: combinational read, write on the edge while ram_rw is high.
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] ref_mem [256];
    assign ram_rdata = env_mem[ram_addr[7:0]];
    always @(posedge clk) if (ram_rw) env_mem[ram_addr[7:0]] <= ram_wdata;

    typedef struct {
        bit            id;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            grant_log[$];
    int            acc_log[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    // Reference model state: who won last, when the arbiter is free, the pending access.
    bit            last_m;
    int            next_free;
    bit            acc_live;
    bit            acc_we;
    int            acc_cyc;
    logic [AW-1:0] lat_addr_m;
    logic [DW-1:0] lat_wdata_m;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Monitor: compares every cycle against the model, pops the scoreboard on responses.
    initial begin
        bit            free, g0, g1, id, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_t          e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("ready_in_rst", {m1_req_ready, m0_req_ready}, 0);
                chk("rsp_in_rst", {m1_rsp_valid, m0_rsp_valid}, 0);
                chk("ram_rw_in_rst", ram_rw, 0);
                exp_q.delete();
                acc_live    = 0;
                last_m      = 1;
                next_free   = cyc + 1;
                lat_addr_m  = '0;
                lat_wdata_m = '0;
            end else begin
                chk("ram_rw", ram_rw, acc_live && (cyc == acc_cyc + 1) && acc_we);
                chk("ram_addr", ram_addr, lat_addr_m);
                chk("ram_wdata", ram_wdata, lat_wdata_m);
                chk("rsp_onehot", m0_rsp_valid & m1_rsp_valid, 0);
                if (m0_rsp_valid || m1_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got m0=%0b m1=%0b expected none (cycle %0d)",
                                 m0_rsp_valid, m1_rsp_valid, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", m1_rsp_valid, e.id);
                        chk("rsp_rdata", e.id ? m1_rsp_rdata : m0_rsp_rdata, e.rdata);
                        chk("rsp_cycle", cyc, e.due);
                    end
                end
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing: got no response expected m%0d at cycle %0d", exp_q[0].id, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
                free = (cyc >= next_free);
                g0   = free && m0_req_valid && (!m1_req_valid || last_m == 1);
                g1   = free && m1_req_valid && (!m0_req_valid || last_m == 0);
                chk("ready", {m1_req_ready, m0_req_ready}, {g1, g0});
                if (m0_req_ready || m1_req_ready) begin
                    grant_log.push_back(m1_req_ready ? 1 : 0);
                    acc_log.push_back(cyc);
                end
                if (g0 || g1) begin
                    id = g1;
                    we = g1 ? m1_req_we : m0_req_we;
                    a  = g1 ? m1_req_addr : m0_req_addr;
                    d  = g1 ? m1_req_wdata : m0_req_wdata;
                    e.id    = id;
                    e.rdata = we ? '0 : ref_mem[a[7:0]];
                    e.due   = cyc + 2;
                    exp_q.push_back(e);
                    if (we) ref_mem[a[7:0]] = d;
                    last_m      = id;
                    next_free   = cyc + 3;
                    acc_live    = 1;
                    acc_we      = we;
                    acc_cyc     = cyc;
                    lat_addr_m  = a;
                    lat_wdata_m = d;
                end
            end
        end
    end

    task automatic drive_req(input bit m, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input bit drop);
        bit done = 0;
        int n = 0;
        if (m == 0) begin
            m0_req_valid = 1; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = data;
        end else begin
            m1_req_valid = 1; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = data;
        end
        while (!done) begin
            @(negedge clk);
            if ((m == 0 && m0_req_ready) || (m == 1 && m1_req_ready)) done = 1;
            @(posedge clk);
            #1;
            n++;
            if (drop) begin
                done = 1;
            end else if (!done && n >= 60) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no ready for m%0d expected accept within 60 cycles", m);
                done = 1;
            end
        end
        if (m == 0) m0_req_valid = 0;
        else        m1_req_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    function automatic void check_order(input string tag, input int n, input bit alt,
                                        input int first, input int gap);
        chk({tag, "_count"}, grant_log.size(), n);
        for (int i = 0; i < n && i < grant_log.size(); i++) begin
            chk({tag, "_grant"}, grant_log[i], alt ? (first ^ (i % 2)) : first);
            if (gap > 0 && i > 0) chk({tag, "_gap"}, acc_log[i] - acc_log[i-1], gap);
        end
    endfunction

    task automatic rand_master(input bit m, input int count);
        for (int k = 0; k < count; k++) begin
            idle($urandom_range(0, 3));
            drive_req(m, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                      ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200us");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        rst = 1;
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        idle(2);

        // Write then read back through m0.
        drive_req(0, 1, 32'h10, 32'hDEADBEEF, 0);
        drive_req(0, 0, 32'h10, 32'h0, 0);
        idle(4);
        chk("a_readback_mem", ref_mem[8'h10], 32'hDEADBEEF);

        // Simultaneous reads right after reset: m0 first, m1 three cycles later.
        do_reset();
        grant_log.delete(); acc_log.delete();
        fork
            drive_req(0, 0, 32'h4, 32'h0, 0);
            drive_req(1, 0, 32'h8, 32'h0, 0);
        join
        idle(5);
        check_order("b_tie", 2, 1, 0, 3);

        // Continuous contention: strict alternation.
        grant_log.delete(); acc_log.delete();
        fork
            for (int k = 0; k < 3; k++) drive_req(0, 0, AW'(k), 32'h0, 0);
            for (int k = 0; k < 3; k++) drive_req(1, 1, AW'(k + 8), $urandom, 0);
        join
        idle(5);
        check_order("c_alt", 6, 1, 0, 3);

        // Single requester back-to-back.
        grant_log.delete(); acc_log.delete();
        for (int k = 0; k < 3; k++) drive_req(1, 0, AW'(k + 20), 32'h0, 0);
        idle(5);
        check_order("d_m1", 3, 0, 1, 3);

        // Reset pulsed during the ACCESS cycle of a write.
        drive_req(0, 1, 32'hF0, 32'h12345678, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("e_outputs_zero", |{m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                                m0_rsp_rdata, m1_rsp_rdata, ram_rw, ram_addr, ram_wdata}, 0);
        idle(4);

        // Randomized traffic from both requesters, including dropped requests.
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        idle(6);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
